// File: rtl/aib_rx_wa_pkg.sv
// aib_rx_wa_pkg: shared state encoding and default configuration for the
// AIB receive word aligner (aib_rx_wordalign and aib_rx_wa_fsm).
package aib_rx_wa_pkg;

  // Alignment FSM states; the encoding is visible on the align_state port.
  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_CHECK  = 2'd1,
    ST_LOCKED = 2'd2
  } align_state_t;

  // Default configuration constants.
  localparam int         DEF_WORD_W   = 8;
  localparam logic [7:0] DEF_MARKER   = 8'hA5;
  localparam int         DEF_LOCK_CNT = 3;
  localparam int         DEF_ERR_W    = 8;

  // match_cnt width; LOCK_CNT is limited to 1..15.
  localparam int         MATCH_CNT_W  = 4;

endpackage

// File: rtl/aib_rx_wa_fsm.sv
// aib_rx_wa_fsm: alignment control for the AIB RX word aligner. Holds the
// SEARCH/CHECK/LOCKED state, the consecutive-marker count, the pair phase
// and the optional CHECK-failure counter (AIB_RX_WORDALIGN_ERRCNT_EN).
module aib_rx_wa_fsm
  import aib_rx_wa_pkg::*;
#(
  parameter int WORD_W   = DEF_WORD_W,
  parameter int LOCK_CNT = DEF_LOCK_CNT,
  parameter int ERR_W    = DEF_ERR_W
) (
  input  logic               clk,
  input  logic               rstb,
  input  logic               rx_en,
  input  logic               align_restart,
  input  logic               marker_hit,
  output align_state_t       state,
  output logic               boundary,
  output logic [ERR_W-1:0]   err_cnt
);

  localparam int PAIRS   = WORD_W / 2;
  localparam int PH_W    = (PAIRS > 1) ? $clog2(PAIRS) : 1;
  localparam int PH_LAST = PAIRS - 1;

  align_state_t            state_nxt;
  logic [MATCH_CNT_W-1:0]  match_cnt, match_cnt_nxt;
  logic [PH_W-1:0]         ph, ph_nxt;

  // The last pair of a word is being sampled this cycle.
  assign boundary = (ph == PH_W'(PH_LAST));

  // State, marker count and pair phase registers.
  always_ff @(posedge clk) begin
    if (!rstb) begin
      state     <= ST_SEARCH;
      match_cnt <= '0;
      ph        <= '0;
    end else begin
      state     <= state_nxt;
      match_cnt <= match_cnt_nxt;
      ph        <= ph_nxt;
    end
  end

  // Next-state logic: disable beats restart, restart beats any marker match.
  always_comb begin
    state_nxt     = state;
    match_cnt_nxt = match_cnt;
    ph_nxt        = ph;
    if (!rx_en) begin
      // Lane idle: phase frozen along with the shift register.
      state_nxt     = ST_SEARCH;
      match_cnt_nxt = '0;
    end else begin
      ph_nxt = boundary ? '0 : PH_W'(ph + 1'b1);
      if (align_restart) begin
        state_nxt     = ST_SEARCH;
        match_cnt_nxt = '0;
      end else begin
        unique case (state)
          ST_SEARCH: begin
            // Sliding compare every cycle; a hit defines the word boundary.
            if (marker_hit) begin
              ph_nxt        = '0;
              match_cnt_nxt = MATCH_CNT_W'(1);
              state_nxt     = (LOCK_CNT == 1) ? ST_LOCKED : ST_CHECK;
            end
          end
          ST_CHECK: begin
            if (boundary) begin
              if (marker_hit) begin
                match_cnt_nxt = match_cnt + MATCH_CNT_W'(1);
                if (match_cnt_nxt == MATCH_CNT_W'(LOCK_CNT)) state_nxt = ST_LOCKED;
              end else begin
                state_nxt     = ST_SEARCH;
                match_cnt_nxt = '0;
              end
            end
          end
          ST_LOCKED: begin
            // No automatic unlock; only restart, disable or reset leave here.
          end
          default: begin
            state_nxt     = ST_SEARCH;
            match_cnt_nxt = '0;
          end
        endcase
      end
    end
  end

`ifdef AIB_RX_WORDALIGN_ERRCNT_EN
  logic [ERR_W-1:0] err_q;
  logic             err_inc;

  // Saturating increment: sticks at all-ones.
  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
    return (&v) ? v : ERR_W'(v + 1'b1);
  endfunction

  // A CHECK failure is a boundary mismatch not overridden by disable/restart.
  assign err_inc = rx_en && !align_restart && (state == ST_CHECK) && boundary && !marker_hit;

  // CHECK-failure counter; cleared only by reset.
  always_ff @(posedge clk) begin
    if (!rstb)        err_q <= '0;
    else if (err_inc) err_q <= sat_inc(err_q);
  end

  assign err_cnt = err_q;
`else
  assign err_cnt = '0;
`endif

endmodule

// File: rtl/aib_rx_wordalign.sv
// aib_rx_wordalign: per-lane RX word aligner behind the DDR capture cell.
// Deserialises two bits per iclkin_dist cycle into WORD_W-bit words, locks
// onto a training MARKER and then streams aligned words with a valid strobe.
// Optional CHECK-failure counter: define AIB_RX_WORDALIGN_ERRCNT_EN.
module aib_rx_wordalign
  import aib_rx_wa_pkg::*;
#(
  parameter int                WORD_W   = DEF_WORD_W,
  parameter logic [WORD_W-1:0] MARKER   = WORD_W'(DEF_MARKER),
  parameter int                LOCK_CNT = DEF_LOCK_CNT,
  parameter int                ERR_W    = DEF_ERR_W
) (
  input  logic              iclkin_dist,
  input  logic              irstb,
  input  logic              rx_en,
  input  logic              idat0,
  input  logic              idat1,
  input  logic              align_restart,
  output logic [WORD_W-1:0] word_out,
  output logic              word_vld,
  output logic              locked,
  output logic [1:0]        align_state,
  output logic [ERR_W-1:0]  err_cnt
);

  logic [WORD_W-1:0] sr, sr_next;
  logic              marker_hit;
  logic              boundary;
  align_state_t      state;
  logic [WORD_W-1:0] word_p1;
  logic              vld_p1;

  // Newest pair enters at the top so that bit 0 ends up as the oldest bit.
  assign sr_next    = {idat1, idat0, sr[WORD_W-1:2]};
  assign marker_hit = (sr_next == MARKER);

  aib_rx_wa_fsm #(
    .WORD_W   (WORD_W),
    .LOCK_CNT (LOCK_CNT),
    .ERR_W    (ERR_W)
  ) u_fsm (
    .clk           (iclkin_dist),
    .rstb          (irstb),
    .rx_en         (rx_en),
    .align_restart (align_restart),
    .marker_hit    (marker_hit),
    .state         (state),
    .boundary      (boundary),
    .err_cnt       (err_cnt)
  );

  // Deserialising shift register, frozen while the lane is disabled.
  always_ff @(posedge iclkin_dist) begin
    if (!irstb)     sr <= '0;
    else if (rx_en) sr <= sr_next;
  end

  // ---- stage p1: registered aligned word and one-cycle valid strobe ----
  // Captures a complete word on each locked boundary; word holds otherwise.
  always_ff @(posedge iclkin_dist) begin
    if (!irstb) begin
      word_p1 <= '0;
      vld_p1  <= 1'b0;
    end else begin
      vld_p1 <= 1'b0;
      if (rx_en && !align_restart && (state == ST_LOCKED) && boundary) begin
        word_p1 <= sr_next;
        vld_p1  <= 1'b1;
      end
    end
  end

  assign word_out    = word_p1;
  assign word_vld    = vld_p1;
  assign locked      = (state == ST_LOCKED);
  assign align_state = state;

endmodule

// File: tb/tb_aib_rx_wordalign.sv
// tb_aib_rx_wordalign: directed self-checking bench for aib_rx_wordalign
// (WORD_W=8, MARKER=8'hA5, LOCK_CNT=3, ERR_W=2). Expected words go into a
// scoreboard queue when driven and are popped when word_vld is seen.
module tb_aib_rx_wordalign;

  logic       clk = 1'b0;
  logic       irstb;
  logic       rx_en;
  logic       idat0;
  logic       idat1;
  logic       align_restart;
  logic [7:0] word_out;
  logic       word_vld;
  logic       locked;
  logic [1:0] align_state;
  logic [1:0] err_cnt;

  int         checks   = 0;
  int         failures = 0;
  logic [7:0] exp_q[$];
  logic [1:0] err_exp  = 2'd0;

  always #5 clk = ~clk;

  aib_rx_wordalign #(
    .WORD_W   (8),
    .MARKER   (8'hA5),
    .LOCK_CNT (3),
    .ERR_W    (2)
  ) dut (
    .iclkin_dist   (clk),
    .irstb         (irstb),
    .rx_en         (rx_en),
    .idat0         (idat0),
    .idat1         (idat1),
    .align_restart (align_restart),
    .word_out      (word_out),
    .word_vld      (word_vld),
    .locked        (locked),
    .align_state   (align_state),
    .err_cnt       (err_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One pair per cycle; returns 1 time unit after the sampling edge.
  task automatic pair(input logic b0, input logic b1);
    idat0 = b0;
    idat1 = b1;
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [7:0] w);
    for (int k = 0; k < 4; k++) pair(w[2*k], w[2*k+1]);
  endtask

  task automatic send_data(input logic [7:0] w);
    exp_q.push_back(w);
    send_word(w);
  endtask

  task automatic bump_err();
`ifdef AIB_RX_WORDALIGN_ERRCNT_EN
    if (err_exp != 2'b11) err_exp = err_exp + 2'd1;
`endif
  endtask

  // Scoreboard: every strobe must match the oldest outstanding word.
  always @(negedge clk) begin
    if (word_vld === 1'b1) begin
      if (exp_q.size() == 0) chk("vld_unexpected", word_vld, 0);
      else                   chk("sb_word", word_out, exp_q.pop_front());
    end
  end

  initial begin
    irstb = 1'b0; rx_en = 1'b1; align_restart = 1'b0; idat0 = 1'b0; idat1 = 1'b0;
    // Reset then idle.
    pair(0, 0);
    pair(0, 0);
    chk("rst_word_out", word_out, 0);
    chk("rst_word_vld", word_vld, 0);
    chk("rst_locked", locked, 0);
    chk("rst_state", align_state, 0);
    chk("rst_err", err_cnt, 0);
    irstb = 1'b1;
    pair(0, 0);
    pair(0, 0);
    pair(0, 0);
    chk("idle_state", align_state, 0);
    chk("idle_vld", word_vld, 0);

    // Clean lock: junk pair, three markers, then data.
    pair(1, 1);
    send_word(8'hA5);
    chk("m1_state", align_state, 1);
    chk("m1_cnt", dut.u_fsm.match_cnt, 1);
    send_word(8'hA5);
    chk("m2_state", align_state, 1);
    send_word(8'hA5);
    chk("m3_state", align_state, 2);
    chk("m3_locked", locked, 1);
    send_data(8'h3C);
    chk("d3c_vld", word_vld, 1);
    chk("d3c_word", word_out, 8'h3C);
    send_data(8'h81);
    send_data(8'hA5);
    chk("marker_as_data_locked", locked, 1);

    // Restart after two pairs of a word.
    pair(0, 0);
    pair(0, 0);
    align_restart = 1'b1;
    pair(1, 1);
    align_restart = 1'b0;
    chk("rs_locked", locked, 0);
    chk("rs_state", align_state, 0);
    pair(1, 1);
    chk("rs_no_vld", word_vld, 0);
    send_word(8'hA5);
    send_word(8'hA5);
    send_word(8'hA5);
    chk("rs_relock", locked, 1);
    send_data(8'h66);
    chk("rs_d66_vld", word_vld, 1);
    chk("rs_d66_word", word_out, 8'h66);

    // rx_en drop in the middle of a marker; sr must hold the first half.
    pair(1, 0);
    pair(1, 0);
    rx_en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      pair(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      chk("en_vld", word_vld, 0);
      chk("en_state", align_state, 0);
      chk("en_word_hold", word_out, 8'h66);
    end
    rx_en = 1'b1;
    pair(0, 1);
    pair(0, 1);
    chk("en_frozen_marker", align_state, 1);
    send_word(8'hA5);
    send_word(8'hA5);
    chk("en_relock", locked, 1);
    send_data(8'h3C);
    chk("en_d3c_word", word_out, 8'h3C);

    // Broken training.
    align_restart = 1'b1;
    pair(0, 0);
    align_restart = 1'b0;
    chk("bt_search", align_state, 0);
    send_word(8'hA5);
    send_word(8'hA5);
    chk("bt_cnt2", dut.u_fsm.match_cnt, 2);
    send_word(8'h5A);
    bump_err();
    chk("bt_state", align_state, 0);
    chk("bt_cnt0", dut.u_fsm.match_cnt, 0);
    chk("bt_err", err_cnt, err_exp);

    // Four more CHECK failures: counter saturates.
    for (int i = 0; i < 4; i++) begin
      send_word(8'hA5);
      chk("sat_check", align_state, 1);
      send_word(8'h5A);
      bump_err();
      chk("sat_search", align_state, 0);
      chk("sat_err", err_cnt, err_exp);
    end

    pair(0, 0);
    pair(0, 0);
    chk("sb_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
